mmio_io_responder: RTL and testbench

- Memory-mapped I/O target on the core's data-memory bus. Responds to the same request signals the core drives toward RAM: enable, 4-bit byte write strobes, 32-bit address and 32-bit write data.
- Gives software register access to the board peripherals:
  - LED register.
  - Seven-segment data register.
  - Debounced switch and button inputs.
  - Sticky button rising-edge flags.
  - Free-running 32-bit cycle timer.
- Sits beside RAM. A top-level address decode steers loads between this block's read data and RAM's.

---
 rtl/mmio_io_responder.sv | 163 ++++++++++++++++
 tb/tb_mmio_io_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O target for LEDs, seven-segment display, switches, buttons and a cycle timer.
// Writes take effect at the request edge. Read data is registered and valid one cycle after the request.
// No wait states: every request is accepted in the cycle it is presented, back-to-back included.
module mmio_io_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic [3:0]  io_write_en,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_hit,
  input  logic [7:0]  switch,
  input  logic [4:0]  btn,
  output logic [7:0]  led,
  output logic [31:0] seg_data
);

  localparam int          NIN      = 13;
  localparam logic [19:0] CNT_LAST = DEBOUNCE_CYCLES - 20'd1;

  localparam logic [5:0] OFF_LED   = 6'h00;
  localparam logic [5:0] OFF_SEG   = 6'h01;
  localparam logic [5:0] OFF_SW    = 6'h02;
  localparam logic [5:0] OFF_BTN   = 6'h03;
  localparam logic [5:0] OFF_EDGE  = 6'h04;
  localparam logic [5:0] OFF_TIMER = 6'h05;

  // Raw inputs packed as {btn, switch} so one synchronizer/debouncer array serves both.
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] deb;
  logic [19:0]    cnt [NIN];

  logic [7:0]  sw_deb;
  logic [4:0]  btn_deb;
  logic [4:0]  btn_deb_q;
  logic [4:0]  edge_flags;
  logic [4:0]  edge_rise;
  logic [4:0]  edge_clr;
  logic [7:0]  led_q;
  logic [31:0] seg_q;
  logic [31:0] timer_q;
  logic [31:0] timer_inc;
  logic [31:0] timer_nxt;

  logic [5:0]  off;
  logic        wr;
  logic        rd;
  logic [31:0] wmask;
  logic [31:0] rd_mux;

  // The two low address bits are don't-care: registers are word-addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^io_addr[1:0];

  assign raw     = {btn, switch};
  assign sw_deb  = deb[7:0];
  assign btn_deb = deb[12:8];

  assign io_hit = io_en && (io_addr[31:8] == BASE_ADDR[31:8]);
  assign off    = io_addr[7:2];
  assign wr     = io_hit && (io_write_en != 4'b0000);
  assign rd     = io_hit && (io_write_en == 4'b0000);
  assign wmask  = {{8{io_write_en[3]}}, {8{io_write_en[2]}},
                   {8{io_write_en[1]}}, {8{io_write_en[0]}}};

  assign led      = led_q;
  assign seg_data = seg_q;

  // Two-flop synchronizer for the asynchronous switch and button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  // Rising edges are detected against last cycle's debounced value; a set beats a same-cycle clear.
  assign edge_rise = btn_deb & ~btn_deb_q;
  assign edge_clr  = (wr && off == OFF_EDGE && io_write_en[0]) ? io_write_data[4:0] : 5'b0;

  // Sticky button edge flags with write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_deb_q  <= '0;
      edge_flags <= '0;
    end else begin
      btn_deb_q  <= btn_deb;
      edge_flags <= (edge_flags & ~edge_clr) | edge_rise;
    end
  end

  // Strobed timer bytes take the write data; the rest follow the increment.
  assign timer_inc = timer_q + 32'd1;
  assign timer_nxt = (wr && off == OFF_TIMER) ?
                     ((timer_inc & ~wmask) | (io_write_data & wmask)) : timer_inc;

  // Writable registers: LED, seven-segment word and the free-running timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      seg_q   <= '0;
      timer_q <= '0;
    end else begin
      timer_q <= timer_nxt;
      if (wr && off == OFF_LED && io_write_en[0]) led_q <= io_write_data[7:0];
      if (wr && off == OFF_SEG) seg_q <= (seg_q & ~wmask) | (io_write_data & wmask);
    end
  end

  // Read-data select; unmapped offsets return zero.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_LED:   rd_mux = {24'h0, led_q};
      OFF_SEG:   rd_mux = seg_q;
      OFF_SW:    rd_mux = {24'h0, sw_deb};
      OFF_BTN:   rd_mux = {27'h0, btn_deb};
      OFF_EDGE:  rd_mux = {27'h0, edge_flags};
      OFF_TIMER: rd_mux = timer_q;
      default:   rd_mux = '0;
    endcase
  end

  // Registered load data; zero in every cycle without a read hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_read_data <= '0;
    end else if (rd) begin
      io_read_data <= rd_mux;
    end else begin
      io_read_data <= '0;
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder with a short debounce window.
// A behavioural model tracks expected register contents and load data cycle by cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmio_io_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          DC   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_en = 1'b0;
  logic [3:0]  io_write_en = 4'h0;
  logic [31:0] io_addr = 32'h0;
  logic [31:0] io_write_data = 32'h0;
  logic [31:0] io_read_data;
  logic        io_hit;
  logic [7:0]  switch = 8'h0;
  logic [4:0]  btn = 5'h0;
  logic [7:0]  led;
  logic [31:0] seg_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_io_responder #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(20'(DC))
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_en(io_en),
    .io_write_en(io_write_en),
    .io_addr(io_addr),
    .io_write_data(io_write_data),
    .io_read_data(io_read_data),
    .io_hit(io_hit),
    .switch(switch),
    .btn(btn),
    .led(led),
    .seg_data(seg_data)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_led, m_sw;
  logic [31:0] m_seg, m_timer, m_rdata;
  logic [4:0]  m_btn, m_btn_q, m_edge;
  logic [7:0]  sw_h [0:DC];
  logic [4:0]  bt_h [0:DC];

  logic        n_hit, n_wr, n_rd;
  logic [5:0]  n_off;
  logic [31:0] n_mask, n_sel, n_seg, n_timer;
  logic [7:0]  n_led, sw_all;
  logic [4:0]  n_clr, bt_all;

  always_comb begin
    n_hit  = io_en && (io_addr[31:8] == BASE[31:8]);
    n_wr   = n_hit && (io_write_en != 4'h0);
    n_rd   = n_hit && (io_write_en == 4'h0);
    n_off  = io_addr[7:2];
    n_mask = {{8{io_write_en[3]}}, {8{io_write_en[2]}}, {8{io_write_en[1]}}, {8{io_write_en[0]}}};
    case (n_off)
      6'd0:    n_sel = {24'h0, m_led};
      6'd1:    n_sel = m_seg;
      6'd2:    n_sel = {24'h0, m_sw};
      6'd3:    n_sel = {27'h0, m_btn};
      6'd4:    n_sel = {27'h0, m_edge};
      6'd5:    n_sel = m_timer;
      default: n_sel = 32'h0;
    endcase
    n_led   = (n_wr && n_off == 6'd0 && io_write_en[0]) ? io_write_data[7:0] : m_led;
    n_seg   = (n_wr && n_off == 6'd1) ? ((m_seg & ~n_mask) | (io_write_data & n_mask)) : m_seg;
    n_timer = (n_wr && n_off == 6'd5) ? (((m_timer + 1) & ~n_mask) | (io_write_data & n_mask))
                                      : m_timer + 1;
    n_clr   = (n_wr && n_off == 6'd4 && io_write_en[0]) ? io_write_data[4:0] : 5'h0;
    // A bit flips once the last DC synchronized samples all disagree with it.
    sw_all = 8'hFF;
    bt_all = 5'h1F;
    for (int j = 1; j <= DC; j++) begin
      sw_all = sw_all & (sw_h[j] ^ m_sw);
      bt_all = bt_all & (bt_h[j] ^ m_btn);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led <= 0; m_seg <= 0; m_timer <= 0; m_rdata <= 0;
      m_sw <= 0; m_btn <= 0; m_btn_q <= 0; m_edge <= 0;
      for (int j = 0; j <= DC; j++) begin
        sw_h[j] <= 0;
        bt_h[j] <= 0;
      end
    end else begin
      m_led   <= n_led;
      m_seg   <= n_seg;
      m_timer <= n_timer;
      m_rdata <= n_rd ? n_sel : 32'h0;
      m_sw    <= m_sw ^ sw_all;
      m_btn   <= m_btn ^ bt_all;
      m_btn_q <= m_btn;
      m_edge  <= (m_edge & ~n_clr) | (m_btn & ~m_btn_q);
      sw_h[0] <= switch;
      bt_h[0] <= btn;
      for (int j = 1; j <= DC; j++) begin
        sw_h[j] <= sw_h[j-1];
        bt_h[j] <= bt_h[j-1];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic [7:0] off, input logic [3:0] we,
                       input logic [31:0] d);
    io_en = en;
    io_addr = BASE + {24'h0, off};
    io_write_en = we;
    io_write_data = d;
  endtask

  task automatic idle();
    io_en = 1'b0;
    io_write_en = 4'h0;
    io_write_data = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (led !== 8'h0) begin n_errors++; $display("FAIL reset_led: got %h expected 00", led); end
    n_checks++; if (seg_data !== 32'h0) begin n_errors++; $display("FAIL reset_seg: got %h expected 0", seg_data); end
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", io_read_data); end
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'h04, 4'h0, 32'h0);
    @(negedge clk);
    idle();
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL reset_read_seg: got %h expected 0", io_read_data); end
  endtask

  task automatic test_seg_strobe();
    drive(1'b1, 8'h04, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, 8'h04, 4'b0011, 32'hA5A5_1234);
    @(negedge clk);
    drive(1'b1, 8'h04, 4'h0, 32'h0);
    n_checks++; if (seg_data !== 32'hFFFF_1234) begin n_errors++; $display("FAIL seg_strobe: got %h expected ffff1234", seg_data); end
    @(negedge clk);
    idle();
    n_checks++; if (io_read_data !== 32'hFFFF_1234) begin n_errors++; $display("FAIL seg_readback: got %h expected ffff1234", io_read_data); end
  endtask

  task automatic test_debounce_glitch();
    for (int len = 2; len <= DC - 1; len++) begin
      switch = 8'h01;
      repeat (len) @(negedge clk);
      switch = 8'h00;
      drive(1'b1, 8'h08, 4'h0, 32'h0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        n_checks++;
        if (io_read_data !== 32'h0 || io_read_data !== m_rdata) begin
          n_errors++; $display("FAIL glitch_len%0d: got %h expected 0", len, io_read_data);
        end
      end
      idle();
    end
  endtask

  task automatic test_debounce_hold();
    switch = 8'h3C;
    drive(1'b1, 8'h08, 4'h0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      logic [31:0] exp;
      @(negedge clk);
      exp = (k >= DC + 3) ? 32'h3C : 32'h0;
      n_checks++;
      if (io_read_data !== exp || io_read_data !== m_rdata) begin
        n_errors++; $display("FAIL debounce_hold k=%0d: got %h expected %h", k, io_read_data, exp);
      end
    end
    idle();
  endtask

  task automatic test_edge_flags();
    btn = 5'h02;
    repeat (10) @(negedge clk);
    drive(1'b1, 8'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (io_read_data !== 32'h2) begin n_errors++; $display("FAIL edge_set: got %h expected 2", io_read_data); end
    n_checks++; if (io_read_data !== m_rdata) begin n_errors++; $display("FAIL edge_set_model: got %h expected %h", io_read_data, m_rdata); end
    drive(1'b1, 8'h10, 4'h1, 32'h2);
    @(negedge clk);
    drive(1'b1, 8'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL edge_clear: got %h expected 0", io_read_data); end
    idle();
    btn = 5'h00;
    repeat (10) @(negedge clk);
    btn = 5'h02;
    repeat (DC + 2) @(negedge clk);
    drive(1'b1, 8'h10, 4'h1, 32'h2);
    @(negedge clk);
    drive(1'b1, 8'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (io_read_data !== 32'h2) begin n_errors++; $display("FAIL edge_set_wins: got %h expected 2", io_read_data); end
    n_checks++; if (io_read_data !== m_rdata) begin n_errors++; $display("FAIL edge_set_wins_model: got %h expected %h", io_read_data, m_rdata); end
    idle();
    btn = 5'h00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timer_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'h0;
    drive(1'b1, 8'h14, 4'hF, 32'hFFFF_FFFE);
    @(negedge clk);
    drive(1'b1, 8'h14, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (io_read_data !== exp[k]) begin
        n_errors++; $display("FAIL timer_wrap %0d: got %h expected %h", k, io_read_data, exp[k]);
      end
    end
    drive(1'b1, 8'h14, 4'b0100, 32'h1234_5678);
    @(negedge clk);
    drive(1'b1, 8'h14, 4'h0, 32'h0);
    @(negedge clk);
    idle();
    n_checks++; if (io_read_data !== m_rdata || io_read_data[23:16] !== 8'h34) begin
      n_errors++; $display("FAIL timer_partial: got %h expected %h", io_read_data, m_rdata);
    end
  endtask

  task automatic test_window();
    drive(1'b1, 8'h00, 4'hF, 32'h5A);
    @(negedge clk);
    io_addr = BASE + 32'h100;
    io_write_data = 32'hFF;
    #1;
    n_checks++; if (io_hit !== 1'b0) begin n_errors++; $display("FAIL window_hit_out: got %b expected 0", io_hit); end
    @(negedge clk);
    n_checks++; if (led !== 8'h5A) begin n_errors++; $display("FAIL window_led: got %h expected 5a", led); end
    drive(1'b0, 8'h00, 4'hF, 32'hFF);
    #1;
    n_checks++; if (io_hit !== 1'b0) begin n_errors++; $display("FAIL window_hit_en0: got %b expected 0", io_hit); end
    @(negedge clk);
    n_checks++; if (led !== 8'h5A) begin n_errors++; $display("FAIL window_led_en0: got %h expected 5a", led); end
    drive(1'b1, 8'h20, 4'h0, 32'h0);
    #1;
    n_checks++; if (io_hit !== 1'b1) begin n_errors++; $display("FAIL window_hit_in: got %b expected 1", io_hit); end
    @(negedge clk);
    idle();
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL window_unmapped: got %h expected 0", io_read_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      logic        exp_hit;
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
      end else begin
        a = BASE + (32'($urandom_range(0, 9)) << 2) + 32'($urandom_range(0, 3));
      end
      io_en = ($urandom_range(0, 9) != 0);
      io_addr = a;
      io_write_en = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      io_write_data = $urandom;
      if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
      if ($urandom_range(0, 15) == 0) btn = 5'($urandom);
      exp_hit = io_en && (a[31:8] == BASE[31:8]);
      #1;
      n_checks++; if (io_hit !== exp_hit) begin n_errors++; $display("FAIL rand_hit c=%0d: got %b expected %b", c, io_hit, exp_hit); end
      @(negedge clk);
      n_checks++; if (io_read_data !== m_rdata) begin n_errors++; $display("FAIL rand_rdata c=%0d: got %h expected %h", c, io_read_data, m_rdata); end
      n_checks++; if (led !== m_led) begin n_errors++; $display("FAIL rand_led c=%0d: got %h expected %h", c, led, m_led); end
      n_checks++; if (seg_data !== m_seg) begin n_errors++; $display("FAIL rand_seg c=%0d: got %h expected %h", c, seg_data, m_seg); end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    drive(1'b1, 8'h04, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b1, 8'h04, 4'h0, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL midreset_rdata: got %h expected 0", io_read_data); end
    n_checks++; if (seg_data !== 32'h0) begin n_errors++; $display("FAIL midreset_seg: got %h expected 0", seg_data); end
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_checks++; if (io_read_data !== 32'h0) begin n_errors++; $display("FAIL midreset_after: got %h expected 0", io_read_data); end
  endtask

  initial begin
    test_reset();
    test_seg_strobe();
    test_debounce_glitch();
    repeat (8) @(negedge clk);
    test_debounce_hold();
    test_edge_flags();
    test_timer_wrap();
    test_window();
    test_random();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
